// File: rtl/poly_cmd_issuer.sv
// Host-side packetizer: one encoded command word, then its operand words, into the accelerator input FIFOs.
// Optional POLY_CMD_ISSUER_ATOMIC_EN holds the command until the data FIFO can take the whole operand burst.
module poly_cmd_issuer #(
  parameter int word_size  = 16,
  parameter int max_degree = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [2:0]           req_a,
  input  logic [4:0]           req_arg,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [word_size-1:0] src_data,
  input  logic                 cmd_full,
  input  logic                 data_full,
  input  logic [10:0]          data_free,
  output logic                 wr_out_command,
  output logic [word_size-1:0] data_out_command,
  output logic                 wr_out_data,
  output logic [word_size-1:0] data_out_data,
  output logic                 done,
  output logic                 err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [2:0] OP_STP = 3'd1;
  localparam logic [2:0] OP_EVP = 3'd2;
  localparam logic [2:0] OP_EVB = 3'd3;
  localparam logic [2:0] OP_RST = 3'd5;

  localparam logic [5:0] MAX_N = 6'(max_degree);

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] arg;
  } req_t;

  logic [2:0]           state;
  req_t                 req_q;
  logic [word_size-1:0] cmd_q;
  logic [5:0]           cnt_q;
  logic [word_size-1:0] enc;
  logic [5:0]           cnt_init;
  logic                 bad;
  logic                 cmd_go;
  logic                 data_go;

  // A is placed in every command; arg only travels for STP/EVB
  always_comb begin
    enc       = '0;
    enc[2:0]  = req_op;
    enc[10:8] = req_a;
    if (req_op == OP_STP || req_op == OP_EVB) enc[7:3] = req_arg;
  end

  always_comb begin
    case (req_op)
      OP_STP:  cnt_init = {1'b0, req_arg} + 6'd1;
      OP_EVP:  cnt_init = 6'd1;
      OP_EVB:  cnt_init = {1'b0, req_arg};
      default: cnt_init = '0;
    endcase
  end

  always_comb begin
    case (req_q.op)
      OP_STP:         bad = ({1'b0, req_q.arg} > MAX_N);
      OP_EVB:         bad = (req_q.arg == 5'd0);
      OP_EVP, OP_RST: bad = 1'b0;
      default:        bad = 1'b1;
    endcase
  end

`ifdef POLY_CMD_ISSUER_ATOMIC_EN
  assign cmd_go = (state == S_CMD) && !cmd_full && (data_free >= {5'd0, cnt_q});
`else
  logic unused_free;
  assign unused_free = ^data_free;
  assign cmd_go = (state == S_CMD) && !cmd_full;
`endif

  assign data_go = (state == S_DATA) && src_valid && !data_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      req_q <= '0;
      cmd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{op: req_op, arg: req_arg};
            cmd_q <= enc;
            cnt_q <= cnt_init;
            state <= S_CHECK;
          end
        end
        S_CHECK: state <= bad ? S_ERR : S_CMD;
        S_CMD: begin
          if (cmd_go) state <= (cnt_q == 6'd0) ? S_DONE : S_DATA;
        end
        S_DATA: begin
          if (data_go) begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // req_ready is masked by reset so every output reads 0 while rst is held low
  assign req_ready        = rst && (state == S_IDLE);
  assign src_ready        = (state == S_DATA) && !data_full;
  assign wr_out_command   = cmd_go;
  assign data_out_command = (state == S_CMD) ? cmd_q : '0;
  assign wr_out_data      = data_go;
  assign data_out_data    = (state == S_DATA) ? src_data : '0;
  assign done             = (state == S_DONE);
  assign err              = (state == S_ERR);

endmodule

// File: tb/tb_poly_cmd_issuer.sv
// Randomized bench for poly_cmd_issuer with a cycle-level packet model derived from the request rules.
module tb_poly_cmd_issuer;
  localparam int MAXD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [2:0]  req_a = '0;
  logic [4:0]  req_arg = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] src_data = '0;
  logic        cmd_full = 1'b0;
  logic        data_full = 1'b0;
  logic [10:0] data_free = 11'd2047;
  logic        wr_out_command;
  logic [15:0] data_out_command;
  logic        wr_out_data;
  logic [15:0] data_out_data;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] ops[$];

  poly_cmd_issuer #(.word_size(16), .max_degree(MAXD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_arg(req_arg),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .cmd_full(cmd_full), .data_full(data_full), .data_free(data_free),
    .wr_out_command(wr_out_command), .data_out_command(data_out_command),
    .wr_out_data(wr_out_data), .data_out_data(data_out_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: no backpressure, 1: random, 2: cmd_full cycles 0-3 and data_full cycles 6-7,
  // 3: data_free starved (4) for the first 5 cycles. abort_at>=0 pulls rst after that many operands.
  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [4:0] arg,
                       input int mode, input int abort_at);
    bit legal, cmd_seen, done_due, fin;
    bit e_cmd, e_srdy, e_wr, e_done, e_err;
    logic [15:0] word;
    int cnt, cyc, idx;
    legal = (op == 3'd1 && int'(arg) <= MAXD) || op == 3'd2 || (op == 3'd3 && arg != 5'd0) || op == 3'd5;
    word  = {5'd0, a, ((op == 3'd1 || op == 3'd3) ? arg : 5'd0), op};
    cnt   = (op == 3'd1) ? int'(arg) + 1 : (op == 3'd2) ? 1 : (op == 3'd3) ? int'(arg) : 0;
    if (!legal) cnt = 0;
    while (ops.size() < cnt) ops.push_back(16'($urandom));

    req_valid = 1'b1; req_op = op; req_a = a; req_arg = arg;
    cmd_full = 1'b0; data_full = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_arg = 5'($urandom);

    cyc = 0; idx = 0; cmd_seen = 0; done_due = 0; fin = 0;
    while (!fin && cyc < 300) begin
      case (mode)
        1: begin
          cmd_full  = ($urandom_range(0, 2) == 0);
          data_full = ($urandom_range(0, 2) == 0);
          src_valid = ($urandom_range(0, 3) != 0);
          data_free = 11'($urandom_range(0, 40));
        end
        2: begin
          cmd_full  = (cyc < 4);
          data_full = (cyc == 6 || cyc == 7);
          src_valid = 1'b1;
          data_free = 11'd2047;
        end
        3: begin
          cmd_full  = 1'b0;
          data_full = 1'b0;
          src_valid = 1'b1;
          data_free = (cyc < 5) ? 11'd4 : 11'd6;
        end
        default: begin
          cmd_full  = 1'b0;
          data_full = 1'b0;
          src_valid = 1'b1;
          data_free = 11'd2047;
        end
      endcase
      src_data = (idx < cnt) ? ops[idx] : 16'($urandom);

      if (abort_at >= 0 && cmd_seen && idx == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ctl", 64'({req_ready, src_ready, wr_out_command, wr_out_data, done, err}), 64'(0));
        chk("abort_data", 64'({data_out_command, data_out_data}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        fin = 1;
      end else begin
        @(negedge clk);
        e_err  = !legal && cyc == 1;
        e_cmd  = legal && cyc >= 1 && !cmd_seen && !cmd_full;
`ifdef POLY_CMD_ISSUER_ATOMIC_EN
        e_cmd  = e_cmd && (int'(data_free) >= cnt);
`endif
        e_srdy = legal && cmd_seen && idx < cnt && !data_full;
        e_wr   = e_srdy && src_valid;
        e_done = done_due;
        chk("err", 64'(err), 64'(e_err));
        chk("wr_cmd", 64'(wr_out_command), 64'(e_cmd));
        chk("src_ready", 64'(src_ready), 64'(e_srdy));
        chk("wr_data", 64'(wr_out_data), 64'(e_wr));
        chk("done", 64'(done), 64'(e_done));
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        if (e_cmd) chk("cmd_word", 64'(data_out_command), 64'(word));
        if (e_wr)  chk("data_word", 64'(data_out_data), 64'(ops[idx]));
        if (e_done || e_err) begin
          fin = 1;
          if (mode == 0 && legal) chk("latency", 64'(cyc), 64'(cnt + 2));
        end
        done_due = (e_cmd && cnt == 0) || (e_wr && idx + 1 == cnt);
        if (e_cmd) cmd_seen = 1;
        if (e_wr) idx++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) chk("timeout", 64'(0), 64'(1));
    ops.delete();
    cmd_full = 1'b0; data_full = 1'b0; src_valid = 1'b0; data_free = 11'd2047;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    logic [2:0] op_tab [8];
    op_tab = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd4, 3'd0};

    @(negedge clk);
    chk("rst_ctl", 64'({req_ready, src_ready, wr_out_command, wr_out_data, done, err}), 64'(0));
    chk("rst_data", 64'({data_out_command, data_out_data}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    ops.push_back(16'h0001); ops.push_back(16'h0002);
    ops.push_back(16'h0003); ops.push_back(16'h0004);
    issue(3'd1, 3'd2, 5'd3, 0, -1);
    ops.push_back(16'h0005);
    issue(3'd2, 3'd1, 5'd9, 0, -1);
    ops.push_back(16'h0010); ops.push_back(16'h0011); ops.push_back(16'h0012);
    issue(3'd3, 3'd0, 5'd3, 2, -1);
    issue(3'd4, 3'd3, 5'd2, 0, -1);
    issue(3'd3, 3'd4, 5'd0, 0, -1);
    issue(3'd1, 3'd5, 5'd31, 0, -1);
    issue(3'd1, 3'd6, 5'd11, 0, -1);
    issue(3'd1, 3'd7, 5'd10, 0, -1);
    issue(3'd5, 3'd0, 5'd0, 2, -1);
    issue(3'd1, 3'd2, 5'd5, 0, 2);
    issue(3'd1, 3'd1, 5'd5, 3, -1);

    for (int i = 0; i < 40; i++) begin
      rop = op_tab[$urandom_range(0, 7)];
      issue(rop, 3'($urandom), 5'($urandom_range(0, 12)), (i % 3 == 0) ? 0 : 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
